eco_patch_sweeper: RTL and testbench

- Sequential exhaustive-check stage that drives the input cone of a combinational ECO patch netlist and consumes its single output.
- Steps through every input vector, waits a settle interval, and compares the patch output against a golden reference bit from the original/spec netlist.
- Reports pass/fail, the number of mismatches, and the first failing vector.
- Sits directly upstream (stimulus) and downstream (capture) of the patch during in-system ECO validation.

---
 rtl/eco_patch_sweeper_if.sv | 34 +++
 rtl/eco_patch_sweeper.sv | 121 ++++++++++++
 tb/tb_eco_patch_sweeper.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/eco_patch_sweeper_if.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// eco_patch_sweeper_if
// Stimulus/capture bundle between the sweeper and the patch under check.
// Revision: 1.0
// ---------------------------------------------------------------------------
interface eco_patch_sweeper_if #(
  parameter int NUM_IN = 4
);
  logic              start;
  logic [NUM_IN-1:0] vec_out;
  logic              patch_in;
  logic              golden_in;
  logic              busy;
  logic              done;
  logic              pass;
  logic [NUM_IN:0]   mismatch_count;
  logic              fail_valid;
  logic [NUM_IN-1:0] first_fail_vec;

  // Sweeper side
  modport slave (
    input  start, patch_in, golden_in,
    output vec_out, busy, done, pass, mismatch_count, fail_valid, first_fail_vec
  );

  // Controller / patch-harness side
  modport master (
    output start, patch_in, golden_in,
    input  vec_out, busy, done, pass, mismatch_count, fail_valid, first_fail_vec
  );
endinterface
`default_nettype wire

// File: rtl/eco_patch_sweeper.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// eco_patch_sweeper
// Walks every input vector of a combinational ECO patch, lets each settle,
// compares the patch output with the golden bit and records the results.
// Revision: 1.0
// ---------------------------------------------------------------------------
module eco_patch_sweeper #(
  parameter int NUM_IN        = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  eco_patch_sweeper_if.slave sw
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  settle_cnt;
  logic [NUM_IN-1:0] vec_r;
  logic              busy_r;
  logic              done_r;
  logic [NUM_IN:0]   count_r;
  logic              fail_valid_r;
  logic [NUM_IN-1:0] first_fail_r;

  logic start_ok;
  logic settle_last;
  logic vec_last;
  logic mismatch;

  // A start is only honoured when no sweep is running.
  assign start_ok    = sw.start && ((state == IDLE) || (state == DONE));
  assign settle_last = (settle_cnt == CNT_LAST);
  assign vec_last    = (vec_r == {NUM_IN{1'b1}});
  assign mismatch    = (sw.patch_in != sw.golden_in);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok)    state_nxt = SETTLE;
      SETTLE:  if (settle_last) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = vec_last ? DONE : SETTLE;
      DONE:    if (start_ok)    state_nxt = SETTLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Vector stepping, settle timing and result capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vec_r        <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      count_r      <= '0;
      fail_valid_r <= 1'b0;
      first_fail_r <= '0;
      settle_cnt   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            vec_r        <= '0;
            busy_r       <= 1'b1;
            done_r       <= 1'b0;
            count_r      <= '0;
            fail_valid_r <= 1'b0;
            first_fail_r <= '0;
            settle_cnt   <= '0;
          end
        end
        SETTLE: settle_cnt <= settle_cnt + 1'b1;
        SAMPLE: begin
          if (mismatch) begin
            count_r <= count_r + 1'b1;
            if (!fail_valid_r) begin
              first_fail_r <= vec_r;
              fail_valid_r <= 1'b1;
            end
          end
          if (vec_last) begin
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end else begin
            vec_r      <= vec_r + 1'b1;
            settle_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign sw.vec_out        = vec_r;
  assign sw.busy           = busy_r;
  assign sw.done           = done_r;
  assign sw.pass           = done_r && (count_r == '0);
  assign sw.mismatch_count = count_r;
  assign sw.fail_valid     = fail_valid_r;
  assign sw.first_fail_vec = first_fail_r;

endmodule
`default_nettype wire

// File: tb/tb_eco_patch_sweeper.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_eco_patch_sweeper
// Directed bench for the ECO patch sweeper (SETTLE_CYCLES = 1 and 3).
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_eco_patch_sweeper;

  localparam int S_VEC  = 0;
  localparam int S_BUSY = 1;
  localparam int S_DONE = 2;
  localparam int S_PASS = 3;
  localparam int S_CNT  = 4;
  localparam int S_FV   = 5;
  localparam int S_FFV  = 6;

  localparam int M_GOOD  = 0;
  localparam int M_FLIP5 = 1;
  localparam int M_STUCK = 2;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   mode1;
  int   mode3;
  int   de;

  eco_patch_sweeper_if #(.NUM_IN(4)) if1 ();
  eco_patch_sweeper_if #(.NUM_IN(4)) if3 ();

  eco_patch_sweeper #(.NUM_IN(4), .SETTLE_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .sw(if1));
  eco_patch_sweeper #(.NUM_IN(4), .SETTLE_CYCLES(3)) dut3 (.clk(clk), .rst_n(rst_n), .sw(if3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Golden function: n36 | (n29 & ~n31 & ~n33)
  function automatic logic gold(input logic [3:0] v);
    return v[3] | (v[0] & ~v[1] & ~v[2]);
  endfunction

  function automatic logic patchf(input int m, input logic [3:0] v);
    if (m == M_STUCK) return 1'b0;
    if (m == M_FLIP5 && v == 4'd5) return ~gold(v);
    return gold(v);
  endfunction

  assign if1.golden_in = gold(if1.vec_out);
  assign if1.patch_in  = patchf(mode1, if1.vec_out);
  assign if3.golden_in = gold(if3.vec_out);
  assign if3.patch_in  = patchf(mode3, if3.vec_out);

  function automatic logic [31:0] sig(input int which, input int id);
    if (which == 0) begin
      case (id)
        S_VEC:   return 32'(if1.vec_out);
        S_BUSY:  return 32'(if1.busy);
        S_DONE:  return 32'(if1.done);
        S_PASS:  return 32'(if1.pass);
        S_CNT:   return 32'(if1.mismatch_count);
        S_FV:    return 32'(if1.fail_valid);
        default: return 32'(if1.first_fail_vec);
      endcase
    end else begin
      case (id)
        S_VEC:   return 32'(if3.vec_out);
        S_BUSY:  return 32'(if3.busy);
        S_DONE:  return 32'(if3.done);
        S_PASS:  return 32'(if3.pass);
        S_CNT:   return 32'(if3.mismatch_count);
        S_FV:    return 32'(if3.fail_valid);
        default: return 32'(if3.first_fail_vec);
      endcase
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_start(input int which, input logic v);
    if (which == 0) if1.start = v;
    else            if3.start = v;
  endtask

  task automatic chk_results(input string tag, input int which, input int cnt,
                             input int fv, input int ffv, input int pass);
    chk({tag, "_busy"}, sig(which, S_BUSY), 0);
    chk({tag, "_pass"}, sig(which, S_PASS), 32'(pass));
    chk({tag, "_cnt"},  sig(which, S_CNT),  32'(cnt));
    chk({tag, "_fv"},   sig(which, S_FV),   32'(fv));
    chk({tag, "_ffv"},  sig(which, S_FFV),  32'(ffv));
    chk({tag, "_vec"},  sig(which, S_VEC),  15);
  endtask

  // Pulses start (sampled at edge 0) and returns the edge after which done is
  // first seen high; an optional second start is raised before edge 'repulse'.
  task automatic sweep(input string tag, input int which, input int repulse,
                       output int done_edge);
    int s;
    s = (which == 0) ? 1 : 3;
    @(negedge clk);
    set_start(which, 1'b1);
    @(posedge clk);
    #1;
    set_start(which, 1'b0);
    chk({tag, "_e0_busy"}, sig(which, S_BUSY), 1);
    chk({tag, "_e0_done"}, sig(which, S_DONE), 0);
    chk({tag, "_e0_cnt"},  sig(which, S_CNT),  0);
    chk({tag, "_e0_fv"},   sig(which, S_FV),   0);
    chk({tag, "_e0_vec"},  sig(which, S_VEC),  0);
    done_edge = -1;
    for (int n = 1; n <= 300; n++) begin
      if (n == repulse) set_start(which, 1'b1);
      @(posedge clk);
      #1;
      set_start(which, 1'b0);
      if (n == s)     chk({tag, "_vec0_hold"}, sig(which, S_VEC), 0);
      if (n == s + 1) chk({tag, "_vec1_step"}, sig(which, S_VEC), 1);
      if (sig(which, S_DONE) == 1) begin
        done_edge = n;
        break;
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    mode1    = M_GOOD;
    mode3    = M_STUCK;
    if1.start = 1'b0;
    if3.start = 1'b0;
    rst_n    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vec",  sig(0, S_VEC),  0);
    chk("rst_busy", sig(0, S_BUSY), 0);
    chk("rst_done", sig(0, S_DONE), 0);
    chk("rst_pass", sig(0, S_PASS), 0);
    chk("rst_cnt",  sig(0, S_CNT),  0);
    chk("rst_fv",   sig(0, S_FV),   0);
    chk("rst_ffv",  sig(0, S_FFV),  0);
    @(negedge clk);
    rst_n = 1'b1;

    // Correct patch
    mode1 = M_GOOD;
    sweep("good", 0, -1, de);
    chk("good_done_edge", 32'(de), 32);
    chk_results("good", 0, 0, 0, 0, 1);

    // Single fault at vector 5, restarted from DONE
    mode1 = M_FLIP5;
    sweep("flip5", 0, -1, de);
    chk("flip5_done_edge", 32'(de), 32);
    chk_results("flip5", 0, 1, 1, 5, 0);

    // Stuck-at-0 patch
    mode1 = M_STUCK;
    sweep("stuck", 0, -1, de);
    chk("stuck_done_edge", 32'(de), 32);
    chk_results("stuck", 0, 9, 1, 1, 0);

    // Start re-pulsed at edge 10 while busy is ignored
    sweep("repulse", 0, 10, de);
    chk("repulse_done_edge", 32'(de), 32);
    chk_results("repulse", 0, 9, 1, 1, 0);

    // Reset at cycle 15 of a sweep aborts it
    @(negedge clk);
    if1.start = 1'b1;
    @(posedge clk);
    #1;
    if1.start = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_vec",  sig(0, S_VEC),  0);
    chk("abort_busy", sig(0, S_BUSY), 0);
    chk("abort_done", sig(0, S_DONE), 0);
    chk("abort_cnt",  sig(0, S_CNT),  0);
    chk("abort_fv",   sig(0, S_FV),   0);
    chk("abort_ffv",  sig(0, S_FFV),  0);
    @(negedge clk);
    rst_n = 1'b1;
    mode1 = M_FLIP5;
    sweep("after_rst", 0, -1, de);
    chk("after_rst_done_edge", 32'(de), 32);
    chk_results("after_rst", 0, 1, 1, 5, 0);

    // SETTLE_CYCLES = 3: stuck run, then restart from DONE with a good patch
    mode3 = M_STUCK;
    sweep("s3_stuck", 1, -1, de);
    chk("s3_stuck_done_edge", 32'(de), 64);
    chk_results("s3_stuck", 1, 9, 1, 1, 0);
    mode3 = M_GOOD;
    sweep("s3_good", 1, -1, de);
    chk("s3_good_done_edge", 32'(de), 64);
    chk_results("s3_good", 1, 0, 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
